conv_neuron_seq: RTL

Time-multiplexed, runtime-programmable successor to the constant-weight, fully combinational convolution neuron. It computes one output pixel, ReLU(Σ x[i]·w[i] + bias), over a CIN×F×F window. It uses LANES signed multipliers per cycle instead of one multiplier per tap. It sits between the window line-buffer (upstream valid/ready) and the per-layer output packer (downstream valid/ready). Weights and bias are loaded through a write port, so a single instance serves any kernel.

---
 rtl/conv_pkg.sv | 21 ++
 rtl/mac_lanes.sv | 27 ++
 rtl/relu.sv | 20 ++
 rtl/conv_neuron_seq.sv | 138 +++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the time-multiplexed convolution neuron.
// - state_t : FSM encoding used by conv_neuron_seq.
// - beats() : number of MAC cycles needed to cover n taps with `lanes` multipliers.
// - *_DEF   : geometry of the default instance.
package conv_pkg;

  typedef enum logic [1:0] {IDLE, MAC, DONE, OUT} state_t;

  localparam int WIDTH_DEF = 8;
  localparam int F_DEF     = 5;
  localparam int CIN_DEF   = 3;
  localparam int LANES_DEF = 4;
  localparam int N_DEF     = CIN_DEF * F_DEF * F_DEF;
  localparam int OUT_W_DEF = 2 * WIDTH_DEF + $clog2(N_DEF);
  localparam int AW_DEF    = $clog2(N_DEF + 1);

  function automatic int beats(input int n, input int lanes);
    return (n + lanes - 1) / lanes;
  endfunction

endpackage

// File: rtl/mac_lanes.sv
// Combinational multiply/add slice: LANES signed WIDTH x WIDTH products summed
// into one partial sum per beat.
// Ports:
//   xl   : LANES signed taps
//   wl   : LANES signed weights
//   psum : signed sum of the LANES products, PSW bits (never overflows)
module mac_lanes #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int PSW   = 2 * WIDTH + $clog2(LANES)
) (
  input  logic signed [WIDTH-1:0] xl [LANES],
  input  logic signed [WIDTH-1:0] wl [LANES],
  output logic signed [PSW-1:0]   psum
);

  logic signed [2*WIDTH-1:0] prod [LANES];

  always_comb begin
    psum = '0;
    for (int k = 0; k < LANES; k++) begin
      prod[k] = xl[k] * wl[k];
      psum    = psum + PSW'(prod[k]);
    end
  end

endmodule

// File: rtl/relu.sv
// Output clamp shared by the neuron designs.
// Ports:
//   a : signed input, W_IN bits
//   y : W_OUT-bit result; 0 when ENABLE and a is negative, otherwise a truncated
//       to W_OUT bits (callers guarantee the truncation is lossless).
module relu #(
  parameter int W_IN   = 24,
  parameter int W_OUT  = 23,
  parameter int ENABLE = 1
) (
  input  logic signed [W_IN-1:0]  a,
  output logic signed [W_OUT-1:0] y
);

  always_comb begin
    if ((ENABLE != 0) && a[W_IN-1]) y = '0;
    else                            y = a[W_OUT-1:0];
  end

endmodule

// File: rtl/conv_neuron_seq.sv
// Time-multiplexed convolution neuron: z = relu(sum x[i]*w[i] + bias) over a
// CIN x F x F window, LANES taps per cycle.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid, in_ready  : window handshake (x captured on acceptance)
//   x                   : N signed taps
//   w_we, w_addr, w_data: weight (addr < N, low WIDTH bits) / bias (addr == N)
//                         write port, honoured only while idle
//   out_valid, out_ready: result handshake
//   z                   : signed result, held while out_valid is high
module conv_neuron_seq
  import conv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int F     = F_DEF,
  parameter int CIN   = CIN_DEF,
  parameter int LANES = LANES_DEF,
  parameter int RELU  = 1,
  parameter int OUT_W = WIDTH * 2 + $clog2(CIN * F * F)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic signed [WIDTH-1:0]             x [CIN*F*F],
  input  logic                                w_we,
  input  logic        [$clog2(CIN*F*F+1)-1:0] w_addr,
  input  logic        [2*WIDTH-1:0]           w_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic signed [OUT_W-1:0]             z
);

  localparam int N     = CIN * F * F;
  localparam int BEATS = beats(N, LANES);
  localparam int NP    = BEATS * LANES;           // taps padded to whole beats
  localparam int AW    = $clog2(N + 1);
  localparam int IW    = (NP > 1) ? $clog2(NP) : 1;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PSW   = 2 * WIDTH + $clog2(LANES);
  localparam int ACW   = OUT_W + 1;

  state_t state, state_d;
  logic [BW-1:0] beat;

  // Padding entries (index >= N) are cleared by reset and never written, so
  // the last beat's surplus lanes multiply zeros.
  logic signed [WIDTH-1:0]   win [NP];
  logic signed [WIDTH-1:0]   wt  [NP];
  logic signed [2*WIDTH-1:0] bias;
  logic signed [ACW-1:0]     acc;

  logic signed [WIDTH-1:0] lx [LANES];
  logic signed [WIDTH-1:0] lw [LANES];
  logic signed [PSW-1:0]   psum;
  logic signed [ACW-1:0]   total;
  logic signed [OUT_W-1:0] relu_y;

  assign in_ready = (state == IDLE);
  assign total    = acc + ACW'(bias);

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      lx[k] = win[IW'(beat) * IW'(LANES) + IW'(k)];
      lw[k] = wt[IW'(beat) * IW'(LANES) + IW'(k)];
    end
  end

  mac_lanes #(.WIDTH(WIDTH), .LANES(LANES), .PSW(PSW)) u_mac (
    .xl  (lx),
    .wl  (lw),
    .psum(psum)
  );

  relu #(.W_IN(ACW), .W_OUT(OUT_W), .ENABLE(RELU)) u_relu (
    .a(total),
    .y(relu_y)
  );

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (in_valid) state_d = MAC;
      MAC:     if (beat == BW'(BEATS - 1)) state_d = DONE;
      DONE:    state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat      <= '0;
      acc       <= '0;
      bias      <= '0;
      z         <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < NP; i++) begin
        win[i] <= '0;
        wt[i]  <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          // A write in the accepting cycle lands before the first MAC beat.
          if (w_we) begin
            for (int i = 0; i < N; i++)
              if (w_addr == AW'(i)) wt[i] <= w_data[WIDTH-1:0];
            if (w_addr == AW'(N)) bias <= w_data;
          end
          if (in_valid) begin
            for (int i = 0; i < N; i++) win[i] <= x[i];
            acc  <= '0;
            beat <= '0;
          end
        end
        MAC: begin
          acc  <= acc + ACW'(psum);
          beat <= beat + 1'b1;
        end
        DONE: begin
          z         <= relu_y;
          out_valid <= 1'b1;
        end
        OUT: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
